// File: rtl/ysyx_22040365_seq.sv
// ysyx_22040365_seq: multi-cycle instruction sequencer.
//
// Walks each instruction through FETCH -> WAIT -> DECODE -> EXEC -> WB. It owns the PC,
// drives the instruction-memory request handshake and latches the fetched word for the
// decoder. It also gates the regfile enables, pulses the EX start and halts on ebreak,
// an illegal opcode or a fetch timeout. Only reset leaves HALT.
//
// Ports:
//   clk, rst                    clock; synchronous active-low reset
//   imem_req/addr/gnt/rvalid/rdata  instruction fetch handshake
//   inst, pc                    latched instruction and current PC
//   id_illegal                  decoder illegal-opcode flag, sampled in DECODE
//   rf_ren, rf_wen              regfile read / gated write enables
//   ex_start, ex_done, ex_wen_rd  EX unit handshake
//   commit                      one-cycle retire pulse
//   halt, halt_code             sticky halt, 1 ebreak / 2 illegal / 3 fetch timeout
//   cycle_cnt, instret          performance counters
//
// Optional feature: define YSYX_22040365_SEQ_PERF_EN to build the cycle and
// retired-instruction counters. Without it both outputs are tied to zero.

module ysyx_22040365_seq #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] EBREAK   = 32'h0010_0073
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [63:0] pc,
    input  logic        id_illegal,
    output logic        rf_ren,
    output logic        ex_start,
    input  logic        ex_done,
    input  logic        ex_wen_rd,
    output logic        rf_wen,
    output logic        commit,
    output logic        halt,
    output logic [1:0]  halt_code,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret
);

    typedef enum logic [2:0] {
        StFetch,
        StWait,
        StDecode,
        StExec,
        StWb,
        StHalt
    } state_e;

    localparam bit          WdogEn   = (TIMEOUT != 0);
    localparam logic [31:0] WdogLast = WdogEn ? 32'(TIMEOUT - 1) : 32'd0;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [1:0]  halt_code_q, halt_code_d;
    logic [31:0] wdog_q, wdog_d;
    // Marks the first EXEC cycle so ex_start is a single pulse.
    logic        ex_first_q, ex_first_d;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StFetch;
            pc_q        <= RESET_PC;
            inst_q      <= '0;
            halt_code_q <= '0;
            wdog_q      <= '0;
            ex_first_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            halt_code_q <= halt_code_d;
            wdog_q      <= wdog_d;
            ex_first_q  <= ex_first_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        halt_code_d = halt_code_q;
        wdog_d      = wdog_q;
        ex_first_d  = 1'b0;
        case (state_q)
            StFetch: begin
                wdog_d = '0;
                if (imem_gnt) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                wdog_d = wdog_q + 32'd1;
                // Data arriving in the last allowed cycle still beats the watchdog.
                if (imem_rvalid) begin
                    inst_d  = imem_rdata;
                    wdog_d  = '0;
                    state_d = StDecode;
                end else if (WdogEn && (wdog_q == WdogLast)) begin
                    halt_code_d = 2'd3;
                    state_d     = StHalt;
                end
            end
            StDecode: begin
                if (inst_q == EBREAK) begin
                    halt_code_d = 2'd1;
                    state_d     = StHalt;
                end else if (id_illegal) begin
                    halt_code_d = 2'd2;
                    state_d     = StHalt;
                end else begin
                    ex_first_d = 1'b1;
                    state_d    = StExec;
                end
            end
            StExec: begin
                if (ex_done) begin
                    state_d = StWb;
                end
            end
            StWb: begin
                pc_d    = pc_q + 64'd4;
                state_d = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // Outputs; strobes are forced low while reset is asserted.
    always_comb begin
        imem_req  = rst && (state_q == StFetch);
        rf_ren    = rst && ((state_q == StDecode) || (state_q == StExec));
        ex_start  = rst && (state_q == StExec) && ex_first_q;
        commit    = rst && (state_q == StWb);
        rf_wen    = rst && (state_q == StWb) && ex_wen_rd;
        halt      = (state_q == StHalt);
        halt_code = halt_code_q;
        imem_addr = pc_q;
        pc        = pc_q;
        inst      = inst_q;
    end

`ifdef YSYX_22040365_SEQ_PERF_EN
    logic [63:0] cycle_q, cycle_d;
    logic [63:0] instret_q, instret_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        cycle_d   = cycle_q;
        instret_d = instret_q;
        if (state_q != StHalt) begin
            cycle_d = cycle_q + 64'd1;
        end
        if (state_q == StWb) begin
            instret_d = instret_q + 64'd1;
        end
    end

    assign cycle_cnt = cycle_q;
    assign instret   = instret_q;
`else
    assign cycle_cnt = '0;
    assign instret   = '0;
`endif

endmodule

// File: tb/tb_ysyx_22040365_seq.sv
// Self-checking bench for ysyx_22040365_seq. A second instance with RESET_PC near the top
// of the address space runs on the same stimulus to exercise PC wrap-around.

module tb_ysyx_22040365_seq;

    localparam logic [63:0] RST_PC     = 64'h8000_0000;
    localparam logic [63:0] WRAP_PC    = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [63:0] WRAP_DELTA = WRAP_PC - RST_PC;
    localparam logic [31:0] EBRK       = 32'h0010_0073;

    logic        clk, rst;
    logic        imem_gnt, imem_rvalid, id_illegal, ex_done, ex_wen_rd;
    logic [31:0] imem_rdata;

    logic        imem_req, rf_ren, ex_start, rf_wen, commit, halt;
    logic [63:0] imem_addr, pc, cycle_cnt, instret;
    logic [31:0] inst;
    logic [1:0]  halt_code;

    logic        imem_req_w, rf_ren_w, ex_start_w, rf_wen_w, commit_w, halt_w;
    logic [63:0] imem_addr_w, pc_w, cycle_cnt_w, instret_w;
    logic [31:0] inst_w;
    logic [1:0]  halt_code_w;

    ysyx_22040365_seq dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst(inst), .pc(pc), .id_illegal(id_illegal),
        .rf_ren(rf_ren), .ex_start(ex_start), .ex_done(ex_done), .ex_wen_rd(ex_wen_rd),
        .rf_wen(rf_wen), .commit(commit), .halt(halt), .halt_code(halt_code),
        .cycle_cnt(cycle_cnt), .instret(instret)
    );

    ysyx_22040365_seq #(.RESET_PC(WRAP_PC)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst(inst_w), .pc(pc_w), .id_illegal(id_illegal),
        .rf_ren(rf_ren_w), .ex_start(ex_start_w), .ex_done(ex_done), .ex_wen_rd(ex_wen_rd),
        .rf_wen(rf_wen_w), .commit(commit_w), .halt(halt_w), .halt_code(halt_code_w),
        .cycle_cnt(cycle_cnt_w), .instret(instret_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [63:0] pc_model;
    logic [31:0] prev_inst;

    typedef struct {
        int          g;    // cycles with gnt low before the grant
        int          r;    // WAIT cycles before rvalid
        int          e;    // EXEC cycles before ex_done
        logic [31:0] d;
        logic        w;
        int          lat;  // expected cycles from first FETCH to commit, inclusive
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic set_idle();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        id_illegal  = 1'b0;
        ex_done     = 1'b0;
        ex_wen_rd   = 1'b0;
    endtask

    task automatic set_random();
        imem_gnt    = rb();
        imem_rvalid = rb();
        imem_rdata  = $urandom();
        id_illegal  = rb();
        ex_done     = rb();
        ex_wen_rd   = rb();
    endtask

    task automatic chk_strobes_low(input string tag);
        chk({tag, "_imem_req"}, 64'(imem_req), 64'd0);
        chk({tag, "_rf_ren"},   64'(rf_ren),   64'd0);
        chk({tag, "_ex_start"}, 64'(ex_start), 64'd0);
        chk({tag, "_rf_wen"},   64'(rf_wen),   64'd0);
        chk({tag, "_commit"},   64'(commit),   64'd0);
    endtask

    // Two reset cycles with garbage on the inputs; leaves rst high just after an edge.
    task automatic do_reset();
        rst = 1'b0;
        set_random();
        @(negedge clk);
        chk_strobes_low("rst_async");
        @(posedge clk); #1;
        set_random();
        @(negedge clk);
        chk_strobes_low("rst");
        chk("rst_pc", pc, RST_PC);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_halt", 64'(halt), 64'd0);
        chk("rst_halt_code", 64'(halt_code), 64'd0);
        chk("rst_cycle_cnt", cycle_cnt, 64'd0);
        chk("rst_instret", instret, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        set_idle();
        pc_model  = RST_PC;
        prev_inst = '0;
    endtask

    // One instruction from its first FETCH cycle. hc != 0 means it should halt out of
    // DECODE, so only cycles up to DECODE are run here.
    task automatic do_instr(input int g, input int r, input int e, input logic [31:0] d,
                            input logic w, input logic ill, input logic [1:0] hc,
                            output int commit_at);
        int dc, len;
        dc        = g + r + 2;
        len       = (hc != 0) ? dc + 1 : g + r + e + 5;
        commit_at = -1;
        for (int k = 0; k < len; k++) begin
            imem_gnt    = (k == g) ? 1'b1 : ((k > g) ? rb() : 1'b0);
            imem_rvalid = (k == g + 1 + r) ? 1'b1 : ((k <= g || k > g + 1 + r) ? rb() : 1'b0);
            imem_rdata  = (k == g + 1 + r) ? d : $urandom();
            id_illegal  = (k == dc) ? ill : rb();
            ex_done     = (k == dc + 1 + e) ? 1'b1 : ((k <= dc || k > dc + 1 + e) ? rb() : 1'b0);
            ex_wen_rd   = (k == len - 1 && hc == 0) ? w : rb();
            @(negedge clk);
            chk("imem_req", 64'(imem_req), 64'(k <= g));
            chk("imem_addr", imem_addr, pc_model);
            chk("pc", pc, pc_model);
            chk("inst", 64'(inst), 64'((k >= dc) ? d : prev_inst));
            chk("rf_ren", 64'(rf_ren), 64'(k >= dc && k <= dc + 1 + e));
            chk("ex_start", 64'(ex_start), 64'(hc == 0 && k == dc + 1));
            chk("commit", 64'(commit), 64'(hc == 0 && k == len - 1));
            chk("rf_wen", 64'(rf_wen), 64'(hc == 0 && k == len - 1 && w));
            chk("halt", 64'(halt), 64'd0);
            chk("halt_code", 64'(halt_code), 64'd0);
            chk("pc_wrap", pc_w, pc_model + WRAP_DELTA);
            if (commit === 1'b1 && commit_at < 0) commit_at = k + 1;
            @(posedge clk); #1;
        end
        if (hc == 0) pc_model = pc_model + 64'd4;
        prev_inst = d;
    endtask

    task automatic check_halted(input int n, input logic [1:0] code, input logic [31:0] inst_exp);
        for (int k = 0; k < n; k++) begin
            set_random();
            @(negedge clk);
            chk("hlt_halt", 64'(halt), 64'd1);
            chk("hlt_code", 64'(halt_code), 64'(code));
            chk_strobes_low("hlt");
            chk("hlt_pc", pc, pc_model);
            chk("hlt_inst", 64'(inst), 64'(inst_exp));
            chk("hlt_pc_wrap", pc_w, pc_model + WRAP_DELTA);
            @(posedge clk); #1;
        end
        set_idle();
    endtask

    initial begin
        int          ca, g, r, e;
        logic [31:0] d;
        logic        w;

        vt[0] = '{g: 0, r: 0,  e: 0, d: 32'h0050_0093, w: 1'b1, lat: 5};
        vt[1] = '{g: 3, r: 2,  e: 0, d: 32'h00a0_0113, w: 1'b1, lat: 10};
        vt[2] = '{g: 0, r: 15, e: 0, d: 32'h0020_81b3, w: 1'b0, lat: 20};
        vt[3] = '{g: 1, r: 0,  e: 3, d: 32'h4020_8233, w: 1'b1, lat: 9};
        vt[4] = '{g: 2, r: 4,  e: 1, d: 32'h0000_0013, w: 1'b0, lat: 12};
        vt[5] = '{g: 0, r: 0,  e: 2, d: 32'h1234_52b7, w: 1'b1, lat: 7};

        rst = 1'b0;
        set_idle();
        do_reset();

        // Table-driven instructions; the first one also takes dut_wrap's PC across zero.
        for (int i = 0; i < 6; i++) begin
            do_instr(vt[i].g, vt[i].r, vt[i].e, vt[i].d, vt[i].w, 1'b0, 2'd0, ca);
            chk("tbl_latency", 64'(ca), 64'(vt[i].lat));
        end
        set_idle();
        @(negedge clk);
        chk("tbl_final_pc", pc, RST_PC + 64'd24);
        chk("tbl_wrap_pc", pc_w, 64'd20);
        @(posedge clk); #1;

        // Ten back-to-back minimum-latency instructions.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            do_instr(0, 0, 0, 32'h0000_0013, rb(), 1'b0, 2'd0, ca);
        end
        set_idle();
        @(negedge clk);
`ifdef YSYX_22040365_SEQ_PERF_EN
        chk("perf_instret", instret, 64'd10);
        chk("perf_cycle_cnt", cycle_cnt, 64'd50);
`else
        chk("perf_instret", instret, 64'd0);
        chk("perf_cycle_cnt", cycle_cnt, 64'd0);
`endif
        @(posedge clk); #1;

        // ebreak halt, held for 20 cycles, cleared by reset.
        do_reset();
        do_instr(0, 0, 0, EBRK, 1'b1, 1'b0, 2'd1, ca);
        check_halted(20, 2'd1, EBRK);
        do_reset();

        // Illegal opcode.
        do_instr(1, 2, 0, 32'h0000_007f, 1'b0, 1'b1, 2'd2, ca);
        check_halted(4, 2'd2, 32'h0000_007f);
        do_reset();

        // ebreak flagged illegal too: ebreak wins.
        do_instr(0, 1, 0, EBRK, 1'b0, 1'b1, 2'd1, ca);
        check_halted(3, 2'd1, EBRK);
        do_reset();

        // Fetch timeout: 16 WAIT cycles without rvalid, late rvalid ignored.
        imem_gnt = 1'b1;
        @(negedge clk);
        chk("to_req", 64'(imem_req), 64'd1);
        @(posedge clk); #1;
        for (int k = 1; k <= 16; k++) begin
            set_random();
            imem_rvalid = 1'b0;
            @(negedge clk);
            chk("to_wait_halt", 64'(halt), 64'd0);
            chk("to_wait_req", 64'(imem_req), 64'd0);
            @(posedge clk); #1;
        end
        set_idle();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        @(negedge clk);
        chk("to_halt", 64'(halt), 64'd1);
        chk("to_code", 64'(halt_code), 64'd3);
        @(posedge clk); #1;
        check_halted(5, 2'd3, 32'h0);

        // Reset during WAIT, then stale rvalid.
        do_reset();
        imem_gnt = 1'b1;
        @(negedge clk);
        chk("rw_req", 64'(imem_req), 64'd1);
        @(posedge clk); #1;
        imem_gnt = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        chk_strobes_low("rw_rst");
        @(posedge clk); #1;
        rst         = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hdead_beef;
        @(negedge clk);
        chk("rw_req_again", 64'(imem_req), 64'd1);
        chk("rw_addr", imem_addr, RST_PC);
        chk("rw_inst", 64'(inst), 64'd0);
        @(posedge clk); #1;
        imem_rvalid = 1'b0;
        @(negedge clk);
        chk("rw_stale", 64'(inst), 64'd0);
        chk("rw_still_fetch", 64'(imem_req), 64'd1);
        @(posedge clk); #1;
        pc_model  = RST_PC;
        prev_inst = '0;
        do_instr(vt[0].g, vt[0].r, vt[0].e, vt[0].d, vt[0].w, 1'b0, 2'd0, ca);
        chk("rw_latency", 64'(ca), 64'd5);

        // Randomized instruction stream.
        for (int i = 0; i < 40; i++) begin
            g = $urandom_range(0, 3);
            r = $urandom_range(0, 15);
            e = $urandom_range(0, 3);
            d = $urandom();
            if (d == EBRK) d = 32'h0000_0013;
            w = rb();
            do_instr(g, r, e, d, w, 1'b0, 2'd0, ca);
            chk("rand_latency", 64'(ca), 64'(g + r + e + 5));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
